mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 15, the maximum number of cycles to wait for mem_ack.
REQ-004 The block SHALL have port clk, input, 1, the single clock, rising edge.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port if_req, input, 1, instruction fetch request from the IF stage.
REQ-007 The block SHALL have port if_addr, input, ADDR_W, fetch address (the PC).
REQ-008 The block SHALL have ports dm_rd and dm_wr, input, 1 each, MEM-stage load and store requests.
REQ-009 The block SHALL have ports dm_addr, input, ADDR_W, and dm_wdata, input, DATA_W: load/store address and store data.
REQ-010 The block SHALL have ports if_rdata, output, DATA_W, and if_valid, output, 1: fetched instruction and its one-cycle valid pulse.
REQ-011 The block SHALL have ports dm_rdata, output, DATA_W, and dm_done, output, 1: load data and the one-cycle completion pulse.
REQ-012 The block SHALL have ports if_stall, output, 1, and pipe_stall, output, 1: IF-stage freeze and whole-pipeline freeze.
REQ-013 The block SHALL have port bus_err, output, 1, a one-cycle timeout pulse.
REQ-014 The block SHALL have ports mem_req, output, 1; mem_we, output, 1; mem_addr, output, ADDR_W; mem_wdata, output, DATA_W: the shared memory port.
REQ-015 The block SHALL have ports mem_rdata, input, DATA_W, and mem_ack, input, 1: memory response.

Function
REQ-016 FSM states SHALL be IDLE, DM_BUSY and IF_BUSY.
REQ-017 In IDLE, an unmasked dm_rd or dm_wr SHALL move the FSM to DM_BUSY; otherwise an unmasked if_req SHALL move it to IF_BUSY. Data always wins a simultaneous request.
REQ-018 dm_rd and dm_wr both high SHALL be treated as a write.
REQ-019 On leaving IDLE, mem_addr SHALL latch {addr[ADDR_W-1:2],2'b00}, mem_wdata SHALL latch dm_wdata, and mem_we SHALL latch dm_wr (0 for fetch).
REQ-020 mem_req SHALL be registered: high in every busy-state cycle, low in IDLE.
REQ-021 mem_ack sampled high in a busy state SHALL return the FSM to IDLE next cycle, pulse dm_done or if_valid for exactly that cycle, and register mem_rdata into dm_rdata or if_rdata.
REQ-022 Minimum latency SHALL be 2 cycles: request sampled at cycle 0, mem_req high at 1, ack at 1, done/valid at 2.
REQ-023 During a requester's done/valid cycle, that requester SHALL be masked from arbitration. The other requester MAY be granted in that same cycle.
REQ-024 A wait counter SHALL clear on entering a busy state and increment each busy cycle without ack.
REQ-025 When the wait counter reaches TIMEOUT, the block SHALL pulse bus_err, drop mem_req, return to IDLE, and pulse the pending done/valid with rdata forced to 0.
REQ-026 pipe_stall SHALL equal (dm_rd|dm_wr) & ~dm_done, combinationally.
REQ-027 if_stall SHALL equal (if_req & ~if_valid) | pipe_stall, combinationally.
REQ-028 if_rdata and dm_rdata SHALL hold their values between completions.
REQ-029 Request inputs SHALL be held stable by the pipeline until completion. Changes to them in a busy state SHALL be ignored.

Reset
REQ-030 Asserting reset low SHALL immediately force IDLE, clear the wait counter, and drive to 0: mem_req, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata, if_valid, dm_done and bus_err.
REQ-031 A transaction in flight when reset asserts SHALL be abandoned, and a late mem_ack after release SHALL be ignored in IDLE.
REQ-032 Arbitration SHALL resume on the first rising clk edge after reset deasserts.

Structure
REQ-033 State encoding (IDLE=2'd0, DM_BUSY=2'd1, IF_BUSY=2'd2) and the default TIMEOUT SHALL be defined in the shared mips32 package/header.
REQ-034 The wait counter SHALL be a sub-module named wait_timer (clear, enable, terminal-count output). All other logic SHALL be flat.

Verification
REQ-035 The bench SHALL cover: reset release, if_req=1, if_addr=0x0000_0004, ack 1 cycle after mem_req -> mem_addr=0x4, mem_we=0, if_valid at cycle 2, if_rdata=mem_rdata.
REQ-036 The bench SHALL cover: if_req and dm_rd at the same cycle, dm_addr=0x100 -> data served first, pipe_stall=1 until dm_done, then fetch served with if_stall=1 throughout.
REQ-037 The bench SHALL cover: dm_wr=1, dm_addr=0x0000_0203, dm_wdata=0xCAFEF00D -> mem_addr=0x200, mem_we=1, mem_wdata=0xCAFEF00D, dm_done one cycle after ack.
REQ-038 The bench SHALL cover: mem_ack held low -> bus_err and dm_done pulse together on the TIMEOUT cycle, dm_rdata=0, mem_req low next cycle.
REQ-039 The bench SHALL cover: reset asserted mid DM_BUSY with ack arriving after release -> all outputs 0, no dm_done, FSM IDLE.
REQ-040 The bench SHALL cover: dm_rd still high on its dm_done cycle -> no second memory access is started.

Source files
------------

// File: rtl/mips32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips32_pkg
//  Description : Shared definitions for the mips32 memory-port arbiter:
//                FSM state encoding, default ack timeout and a small helper.
//  Revision    : 1.0  initial release
// ============================================================================
package mips32_pkg;

    // Arbiter FSM state encoding
    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_DM_BUSY = 2'd1;
    localparam logic [1:0] c_IF_BUSY = 2'd2;

    // Default number of cycles a memory access may wait for mem_ack
    localparam int c_TIMEOUT_DEFAULT = 15;

    // Any state other than IDLE owns the shared memory port
    function automatic logic is_busy(input logic [1:0] state);
        return (state != c_IDLE);
    endfunction

endpackage : mips32_pkg
`default_nettype wire

// File: rtl/wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : wait_timer
//  Description : Counts busy cycles spent waiting for a memory ack.
//                o_tc is high in the cycle whose increment would bring the
//                count to TIMEOUT, so the owner can give up at that edge.
//  Ports       : clk      - clock, rising edge
//                reset    - asynchronous active-low reset
//                i_clear  - synchronous clear (has priority over enable)
//                i_enable - increment by one this cycle
//                o_tc     - terminal count reached this cycle
//  Revision    : 1.0  initial release
// ============================================================================
module wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);

    localparam int c_CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = (r_count == c_CNT_W'(TIMEOUT - 1));

endmodule : wait_timer
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one memory port between the IF stage (fetch) and the
//                MEM stage (load/store). Data requests win ties; each access
//                completes on mem_ack or is abandoned with bus_err after
//                TIMEOUT busy cycles.
//  Ports       : clk, reset (async active-low)
//                if_req/if_addr           - fetch request
//                dm_rd/dm_wr/dm_addr/dm_wdata - load/store request
//                if_rdata/if_valid        - fetch result and 1-cycle pulse
//                dm_rdata/dm_done         - load result and 1-cycle pulse
//                if_stall/pipe_stall      - stage freezes (combinational)
//                bus_err                  - 1-cycle timeout pulse
//                mem_req/mem_we/mem_addr/mem_wdata - memory port (registered)
//                mem_rdata/mem_ack        - memory response
//  Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter
    import mips32_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = c_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              dm_rd,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              if_stall,
    output logic              pipe_stall,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    // Word alignment: drop the byte offset
    localparam logic [ADDR_W-1:0] c_ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;
    logic              r_if_valid;
    logic              r_dm_done;
    logic              r_bus_err;

    logic              w_dm_req;
    logic              w_dm_go;
    logic              w_if_go;
    logic              w_busy;
    logic              w_tc;
    logic              w_finish;
    logic              w_grant;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_cpl_data;

    // A requester on its completion cycle is still holding its request
    // (the pipeline only advances at the next edge), so mask it to avoid
    // launching a duplicate access.
    assign w_dm_req   = dm_rd | dm_wr;
    assign w_dm_go    = w_dm_req & ~r_dm_done;
    assign w_if_go    = if_req & ~r_if_valid;
    assign w_busy     = is_busy(r_state);
    assign w_finish   = w_busy & (mem_ack | w_tc);
    assign w_grant    = (r_state == c_IDLE) & (w_dm_go | w_if_go);
    assign w_sel_addr = w_dm_go ? dm_addr : if_addr;
    // A timed-out access completes with zero data
    assign w_cpl_data = mem_ack ? mem_rdata : '0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_dm_go) begin
                    w_state_nxt = c_DM_BUSY;
                end else if (w_if_go) begin
                    w_state_nxt = c_IF_BUSY;
                end
            end
            c_DM_BUSY, c_IF_BUSY: begin
                if (mem_ack || w_tc) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_if_valid  <= 1'b0;
            r_dm_done   <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_mem_req  <= is_busy(w_state_nxt);
            r_if_valid <= 1'b0;
            r_dm_done  <= 1'b0;
            r_bus_err  <= 1'b0;
            if (w_grant) begin
                r_mem_addr  <= w_sel_addr & c_ALIGN_MASK;
                r_mem_wdata <= dm_wdata;
                // rd+wr together counts as a write; fetches never write
                r_mem_we    <= w_dm_go & dm_wr;
            end
            if (w_finish) begin
                r_bus_err <= ~mem_ack;
                if (r_state == c_DM_BUSY) begin
                    r_dm_done  <= 1'b1;
                    r_dm_rdata <= w_cpl_data;
                end else begin
                    r_if_valid <= 1'b1;
                    r_if_rdata <= w_cpl_data;
                end
            end
        end
    end

    // Cleared throughout IDLE so every access starts counting from zero
    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (~w_busy),
        .i_enable (w_busy & ~mem_ack),
        .o_tc     (w_tc)
    );

    assign pipe_stall = w_dm_req & ~r_dm_done;
    assign if_stall   = (if_req & ~r_if_valid) | pipe_stall;

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_rdata  = r_if_rdata;
    assign if_valid  = r_if_valid;
    assign dm_rdata  = r_dm_rdata;
    assign dm_done   = r_dm_done;
    assign bus_err   = r_bus_err;

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter. A behavioural
//                memory answers mem_req after a programmable latency; expected
//                accesses and completions are queued when requests are driven
//                and compared when the DUT presents them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;
    import mips32_pkg::*;

    localparam int TMO = c_TIMEOUT_DEFAULT;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, dm_rd, dm_wr, mem_ack;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_valid, dm_done, if_stall, pipe_stall, bus_err, mem_req, mem_we;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) u_dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr),
        .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_rdata(dm_rdata), .dm_done(dm_done),
        .if_stall(if_stall), .pipe_stall(pipe_stall), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    typedef struct { bit is_dm; logic [31:0] rdata; bit err; } cpl_t;
    typedef struct { logic [31:0] addr; bit we; logic [31:0] wdata; } acc_t;

    cpl_t cpl_q[$];
    acc_t acc_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ack_lat;
    int req_cyc = 0;
    int last_ack_cyc = -1;
    bit late_ack;
    int n;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_acc(input logic [31:0] a, input bit we, input logic [31:0] wd);
        acc_t e;
        e.addr = a; e.we = we; e.wdata = wd;
        acc_q.push_back(e);
    endtask

    task automatic push_cpl(input bit is_dm, input logic [31:0] rd, input bit err);
        cpl_t e;
        e.is_dm = is_dm; e.rdata = rd; e.err = err;
        cpl_q.push_back(e);
    endtask

    // Advance one cycle, then act as memory and check accesses/completions
    task automatic step();
        acc_t a;
        cpl_t c;
        @(posedge clk);
        #1;
        cyc++;
        if (mem_req) begin
            req_cyc++;
            if (req_cyc == 1) begin
                check_eq("acc_expected", 64'(acc_q.size() != 0), 1);
                if (acc_q.size() != 0) begin
                    a = acc_q.pop_front();
                    check_eq("acc_addr", mem_addr, a.addr);
                    check_eq("acc_we", mem_we, a.we);
                    check_eq("acc_wdata", mem_wdata, a.wdata);
                end
            end
            mem_ack   = (ack_lat != 0) && (req_cyc == ack_lat);
            mem_rdata = mem_ack ? mem_model(mem_addr) : 32'hBAD0_BAD0;
            if (mem_ack) last_ack_cyc = cyc;
        end else begin
            req_cyc   = 0;
            mem_ack   = late_ack;
            mem_rdata = late_ack ? 32'h1111_2222 : 32'hBAD0_BAD0;
        end
        if (dm_done || if_valid) begin
            check_eq("cpl_expected", 64'(cpl_q.size() != 0), 1);
            if (cpl_q.size() != 0) begin
                c = cpl_q.pop_front();
                check_eq("cpl_kind_dm", dm_done, c.is_dm);
                if (c.is_dm) check_eq("cpl_dm_rdata", dm_rdata, c.rdata);
                else         check_eq("cpl_if_rdata", if_rdata, c.rdata);
                check_eq("cpl_bus_err", bus_err, c.err);
            end
        end else begin
            check_eq("bus_err_idle", bus_err, 0);
        end
    endtask

    task automatic wait_dm(input int budget);
        n = 0;
        do begin step(); n++; end while (!dm_done && n < budget);
        check_eq("dm_done_seen", dm_done, 1);
    endtask

    task automatic wait_if(input int budget);
        n = 0;
        do begin step(); n++; end while (!if_valid && n < budget);
        check_eq("if_valid_seen", if_valid, 1);
    endtask

    initial begin
        int reqs;
        reset = 1'b0; if_req = 0; dm_rd = 0; dm_wr = 0; mem_ack = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
        ack_lat = 1; late_ack = 0;

        // ---------------- reset state ----------------
        repeat (3) step();
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_if_valid", if_valid, 0);
        check_eq("rst_dm_rdata", dm_rdata, 0);
        reset = 1'b1;
        step();

        // ---------------- single fetch, minimum latency ----------------
        if_req = 1; if_addr = 32'h0000_0004;
        push_acc(32'h4, 0, dm_wdata);
        push_cpl(0, mem_model(32'h4), 0);
        step();
        check_eq("t1_mem_req_c1", mem_req, 1);
        check_eq("t1_mem_addr", mem_addr, 32'h4);
        check_eq("t1_mem_we", mem_we, 0);
        check_eq("t1_if_stall", if_stall, 1);
        step();
        check_eq("t1_if_valid_c2", if_valid, 1);
        check_eq("t1_if_stall_done", if_stall, 0);
        step();
        check_eq("t1_no_refetch", mem_req, 0);
        if_req = 0;
        repeat (3) step();
        check_eq("t1_if_rdata_hold", if_rdata, mem_model(32'h4));

        // ---------------- simultaneous fetch + load ----------------
        ack_lat = 2;
        if_req = 1; if_addr = 32'h40; dm_rd = 1; dm_addr = 32'h100;
        push_acc(32'h100, 0, dm_wdata);
        push_acc(32'h40, 0, dm_wdata);
        push_cpl(1, mem_model(32'h100), 0);
        push_cpl(0, mem_model(32'h40), 0);
        n = 0;
        do begin
            step(); n++;
            if (!dm_done) begin
                check_eq("t2_pipe_stall", pipe_stall, 1);
                check_eq("t2_if_stall_dm", if_stall, 1);
            end
        end while (!dm_done && n < 20);
        check_eq("t2_dm_first", dm_done, 1);
        check_eq("t2_pipe_stall_done", pipe_stall, 0);
        check_eq("t2_if_stall_on_dm_done", if_stall, 1);
        step();
        check_eq("t2_fetch_granted", mem_req, 1);
        dm_rd = 0;
        n = 0;
        do begin
            step(); n++;
            if (!if_valid) begin
                check_eq("t2_if_stall_fetch", if_stall, 1);
                check_eq("t2_pipe_stall_free", pipe_stall, 0);
            end
        end while (!if_valid && n < 20);
        check_eq("t2_if_valid", if_valid, 1);
        check_eq("t2_dm_rdata_hold", dm_rdata, mem_model(32'h100));
        step();
        if_req = 0;
        check_eq("t2_idle_after", mem_req, 0);

        // ---------------- store, unaligned address ----------------
        ack_lat = 3;
        dm_wr = 1; dm_addr = 32'h0000_0203; dm_wdata = 32'hCAFE_F00D;
        push_acc(32'h200, 1, 32'hCAFE_F00D);
        push_cpl(1, mem_model(32'h200), 0);
        step();
        check_eq("t3_mem_addr", mem_addr, 32'h200);
        check_eq("t3_mem_we", mem_we, 1);
        check_eq("t3_mem_wdata", mem_wdata, 32'hCAFE_F00D);
        wait_dm(20);
        check_eq("t3_done_after_ack", 64'(cyc), 64'(last_ack_cyc + 1));
        step();
        check_eq("t3_no_second_access", mem_req, 0);
        dm_wr = 0;

        // ---------------- rd+wr together is a write ----------------
        ack_lat = 1;
        dm_rd = 1; dm_wr = 1; dm_addr = 32'h304; dm_wdata = 32'h0BAD_CAFE;
        push_acc(32'h304, 1, 32'h0BAD_CAFE);
        push_cpl(1, mem_model(32'h304), 0);
        wait_dm(10);
        step();
        dm_rd = 0; dm_wr = 0;

        // ---------------- timeout on a load ----------------
        ack_lat = 0;
        dm_rd = 1; dm_addr = 32'h80; dm_wdata = 32'h0;
        push_acc(32'h80, 0, 32'h0);
        push_cpl(1, 32'h0, 1);
        reqs = 0;
        n = 0;
        do begin
            step(); n++;
            if (mem_req) reqs++;
        end while (!dm_done && n < 40);
        check_eq("t4_dm_done", dm_done, 1);
        check_eq("t4_bus_err", bus_err, 1);
        check_eq("t4_req_cycles", 64'(reqs), 64'(TMO));
        check_eq("t4_req_low_err", mem_req, 0);
        step();
        check_eq("t4_req_low_next", mem_req, 0);
        check_eq("t4_err_pulse", bus_err, 0);
        dm_rd = 0;

        // ---------------- reset in the middle of DM_BUSY ----------------
        dm_rd = 1; dm_addr = 32'h500;
        push_acc(32'h500, 0, dm_wdata);
        step();
        step();
        check_eq("t5_busy", mem_req, 1);
        #2;
        reset = 1'b0;
        dm_rd = 0;
        #1;
        check_eq("t5_rst_mem_req", mem_req, 0);
        check_eq("t5_rst_mem_we", mem_we, 0);
        check_eq("t5_rst_mem_addr", mem_addr, 0);
        check_eq("t5_rst_mem_wdata", mem_wdata, 0);
        check_eq("t5_rst_if_rdata", if_rdata, 0);
        check_eq("t5_rst_dm_rdata", dm_rdata, 0);
        check_eq("t5_rst_pulses", {if_valid, dm_done, bus_err}, 3'b000);
        step();
        step();
        reset = 1'b1;
        late_ack = 1;
        step();
        late_ack = 0;
        step();
        check_eq("t5_no_dm_done", dm_done, 0);
        check_eq("t5_idle_req", mem_req, 0);
        step();
        check_eq("t5_still_idle", mem_req, 0);

        // ---------------- arbitration resumes after reset ----------------
        ack_lat = 2;
        if_req = 1; if_addr = 32'h1002;
        push_acc(32'h1000, 0, dm_wdata);
        push_cpl(0, mem_model(32'h1000), 0);
        step();
        check_eq("t6_resume_req", mem_req, 1);
        wait_if(10);
        step();
        if_req = 0;
        repeat (2) step();

        check_eq("acc_q_drained", 64'(acc_q.size()), 0);
        check_eq("cpl_q_drained", 64'(cpl_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute guard so the run can never hang
    initial begin
        #100000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1, "bench time limit exceeded");
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
